serial_add_ctrl: RTL

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one fullAdder, LSB first, WIDTH cycles per
// operation, with valid/ready handshakes on both sides and an in-flight abort.

module fullAdder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);
    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_add_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             busy
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   sa;
    logic [WIDTH-1:0]   sb;
    logic [WIDTH-2:0]   acc;
    logic               carry;
    logic [CW-1:0]      cnt;
    logic               s;
    logic               co;
    logic [WIDTH-1:0]   shifted;

    fullAdder u_fa (
        .A   (sa[0]),
        .B   (sb[0]),
        .Cin (carry),
        .S   (s),
        .Cout(co)
    );

    // Partial sum is kept apart from result so an abort leaves the last result intact.
    assign shifted = {s, acc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sa        <= '0;
            sb        <= '0;
            acc       <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sa       <= a;
                        sb       <= op_sub ? ~b : b;
                        carry    <= op_sub;
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                    end else begin
                        sa    <= {1'b0, sa[WIDTH-1:1]};
                        sb    <= {1'b0, sb[WIDTH-1:1]};
                        acc   <= shifted[WIDTH-1:1];
                        carry <= co;
                        if (cnt == LAST) begin
                            cnt       <= '0;
                            state     <= DONE;
                            busy      <= 1'b0;
                            out_valid <= 1'b1;
                            result    <= shifted;
                            cout      <= co;
                            ovf       <= carry ^ co;
                            zero      <= ~|shifted;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule
